uart_cmd_ctrl: RTL and testbench

//  Command sequencer between the UART RX/TX FIFOs and the application core (stopwatch/watch).

---
 rtl/uart_cmd_ctrl.sv | 149 ++++++++++++++
 tb/tb_uart_cmd_ctrl.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_ctrl.sv
// uart_cmd_ctrl: command sequencer between the UART RX/TX FIFOs and the
// stopwatch/watch core. Pops one ASCII byte at a time, decodes it into
// control levels/pulses and answers with an echo or a NAK byte.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   rx_empty/rx_rdata RX FIFO status and read data (valid cycle after rx_rd)
//   rx_rd             RX FIFO pop strobe (combinational from state, IDLE only)
//   tx_full           TX FIFO full flag
//   tx_wr/tx_wdata    TX FIFO push strobe (combinational from state, SEND only)
//                     and registered response byte
//   run_o, mode_o     levels toggled by 'R' / 'M'
//   clear_o, up_o,    one-cycle pulses for 'C' / 'U' / 'D'
//   down_o
//   err_cnt           saturating count of unrecognised bytes
module uart_cmd_ctrl #(
  parameter bit         ECHO_EN   = 1'b1,
  parameter logic [7:0] NAK_CHAR  = 8'h3F,
  parameter bit         CASE_FOLD = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_empty,
  input  logic [7:0] rx_rdata,
  output logic       rx_rd,
  input  logic       tx_full,
  output logic       tx_wr,
  output logic [7:0] tx_wdata,
  output logic       run_o,
  output logic       mode_o,
  output logic       clear_o,
  output logic       up_o,
  output logic       down_o,
  output logic [7:0] err_cnt
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_FETCH  = 2'd1;
  localparam logic [1:0] S_DECODE = 2'd2;
  localparam logic [1:0] S_SEND   = 2'd3;

  localparam logic [7:0] CH_R = 8'h52;
  localparam logic [7:0] CH_M = 8'h4D;
  localparam logic [7:0] CH_C = 8'h43;
  localparam logic [7:0] CH_U = 8'h55;
  localparam logic [7:0] CH_D = 8'h44;

  logic [1:0] state_q, state_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] resp_q, resp_d;
  logic       run_q, run_d;
  logic       mode_q, mode_d;
  logic       clear_q, clear_d;
  logic       up_q, up_d;
  logic       down_q, down_d;
  logic [7:0] err_q, err_d;

  logic [7:0] folded;
  logic       is_valid;

  // Case fold touches only 'a'..'z'; everything else passes unchanged.
  always_comb begin
    folded = cmd_q;
    if (CASE_FOLD && (cmd_q >= 8'h61) && (cmd_q <= 8'h7A)) begin
      folded = cmd_q - 8'h20;
    end
  end

  assign is_valid = (folded == CH_R) || (folded == CH_M) || (folded == CH_C) ||
                    (folded == CH_U) || (folded == CH_D);

  // FIFO strobes depend only on state and flags so the pop/push happens in
  // the same cycle the decision is made; both are suppressed while in reset.
  assign rx_rd    = !rst && (state_q == S_IDLE) && !rx_empty;
  assign tx_wr    = !rst && (state_q == S_SEND) && !tx_full;
  assign tx_wdata = resp_q;

  assign run_o   = run_q;
  assign mode_o  = mode_q;
  assign clear_o = clear_q;
  assign up_o    = up_q;
  assign down_o  = down_q;
  assign err_cnt = err_q;

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    cmd_d   = cmd_q;
    resp_d  = resp_q;
    run_d   = run_q;
    mode_d  = mode_q;
    clear_d = 1'b0;
    up_d    = 1'b0;
    down_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      S_IDLE: begin
        if (!rx_empty) state_d = S_FETCH;
      end
      S_FETCH: begin
        cmd_d   = rx_rdata;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        case (folded)
          CH_R:    run_d   = !run_q;
          CH_M:    mode_d  = !mode_q;
          CH_C:    clear_d = 1'b1;
          CH_U:    up_d    = 1'b1;
          CH_D:    down_d  = 1'b1;
          default: if (err_q != 8'hFF) err_d = err_q + 8'd1;
        endcase
        resp_d  = is_valid ? folded : NAK_CHAR;
        state_d = (is_valid && !ECHO_EN) ? S_IDLE : S_SEND;
      end
      S_SEND: begin
        if (!tx_full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cmd_q   <= 8'h00;
      resp_q  <= 8'h00;
      run_q   <= 1'b0;
      mode_q  <= 1'b0;
      clear_q <= 1'b0;
      up_q    <= 1'b0;
      down_q  <= 1'b0;
      err_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      cmd_q   <= cmd_d;
      resp_q  <= resp_d;
      run_q   <= run_d;
      mode_q  <= mode_d;
      clear_q <= clear_d;
      up_q    <= up_d;
      down_q  <= down_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl with behavioural RX/TX FIFO models and a
// scoreboard of expected TX bytes.
module tb_uart_cmd_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_empty;
  logic [7:0] rx_rdata;
  logic       rx_rd;
  logic       tx_full;
  logic       tx_wr;
  logic [7:0] tx_wdata;
  logic       run_o, mode_o, clear_o, up_o, down_o;
  logic [7:0] err_cnt;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] exp_q[$];
  logic [7:0] tx_log[$];
  int overlap = 0;
  int up_n = 0, clr_n = 0, dn_n = 0;

  always #5 clk = ~clk;

  uart_cmd_ctrl dut (
    .clk(clk), .rst(rst),
    .rx_empty(rx_empty), .rx_rdata(rx_rdata), .rx_rd(rx_rd),
    .tx_full(tx_full), .tx_wr(tx_wr), .tx_wdata(tx_wdata),
    .run_o(run_o), .mode_o(mode_o), .clear_o(clear_o),
    .up_o(up_o), .down_o(down_o), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample strobes mid-cycle, then let the FIFO models react to the edge.
  task automatic tick();
    logic rd, wr;
    logic [7:0] wd;
    @(negedge clk);
    rd = rx_rd; wr = tx_wr; wd = tx_wdata;
    if (rd && wr) overlap++;
    if (up_o) up_n++;
    if (clear_o) clr_n++;
    if (down_o) dn_n++;
    @(posedge clk);
    #1;
    if (rd && rx_q.size() > 0) rx_rdata = rx_q.pop_front();
    rx_empty = (rx_q.size() == 0);
    if (wr) tx_log.push_back(wd);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic push(input logic [7:0] b, input logic [7:0] resp, input bit has_resp);
    rx_q.push_back(b);
    rx_empty = 1'b0;
    if (has_resp) exp_q.push_back(resp);
  endtask

  task automatic drain(input string tag);
    logic [7:0] o, e;
    chk({tag, "_count"}, 32'(tx_log.size()), 32'(exp_q.size()));
    while (tx_log.size() > 0 && exp_q.size() > 0) begin
      o = tx_log.pop_front();
      e = exp_q.pop_front();
      chk({tag, "_byte"}, 32'(o), 32'(e));
    end
    tx_log.delete();
    exp_q.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    ticks(2);
    chk("rst_run", 32'(run_o), 0);
    chk("rst_mode", 32'(mode_o), 0);
    chk("rst_err", 32'(err_cnt), 0);
    chk("rst_strobes", 32'({rx_rd, tx_wr, clear_o, up_o, down_o}), 0);
    rst = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; rx_empty = 1'b1; rx_rdata = 8'h00; tx_full = 1'b0;
    do_reset();

    // 1: single 'R' with exact latency
    push(8'h52, 8'h52, 1);
    #1 chk("t1_rd", 32'(rx_rd), 1);
    tick(); chk("t1_rd_once", 32'(rx_rd), 0);
    tick(); chk("t1_run_pre", 32'(run_o), 0);
    tick();
    chk("t1_run", 32'(run_o), 1);
    chk("t1_txwr", 32'(tx_wr), 1);
    chk("t1_txdata", 32'(tx_wdata), 'h52);
    ticks(3); chk("t1_run_hold", 32'(run_o), 1);
    drain("t1");

    // 2: 'r' then 'R' -> toggle twice, both echoes folded
    do_reset();
    push(8'h72, 8'h52, 1);
    push(8'h52, 8'h52, 1);
    #1;
    ticks(3); chk("t2_run1", 32'(run_o), 1);
    ticks(4); chk("t2_run2", 32'(run_o), 0);
    ticks(3);
    chk("t2_err", 32'(err_cnt), 0);
    drain("t2");

    // 3: 'U','C','D' back to back, one pulse each 4 cycles apart
    up_n = 0; clr_n = 0; dn_n = 0;
    push(8'h55, 8'h55, 1);
    push(8'h43, 8'h43, 1);
    push(8'h44, 8'h44, 1);
    #1;
    ticks(3); chk("t3_up", 32'(up_o), 1);
    tick();   chk("t3_up_end", 32'(up_o), 0);
    ticks(3); chk("t3_clr", 32'(clear_o), 1);
    ticks(4); chk("t3_dn", 32'(down_o), 1);
    ticks(4);
    chk("t3_up_n", 32'(up_n), 1);
    chk("t3_clr_n", 32'(clr_n), 1);
    chk("t3_dn_n", 32'(dn_n), 1);
    drain("t3");

    // 4: unrecognised byte, then saturation of the error counter
    push(8'h58, 8'h3F, 1);
    ticks(6);
    chk("t4_err1", 32'(err_cnt), 1);
    chk("t4_levels", 32'({run_o, mode_o}), 0);
    drain("t4a");
    for (int i = 0; i < 300; i++) begin
      case (i % 3)
        0:       push(8'h00, 8'h3F, 1);
        1:       push(8'h80 | 8'(i), 8'h3F, 1);
        default: push(8'h7A, 8'h3F, 1);
      endcase
    end
    ticks(1230);
    chk("t4_err_sat", 32'(err_cnt), 'hFF);
    drain("t4b");

    // 5: TX back-pressure holds the echo and blocks the next pop
    tx_full = 1'b1;
    push(8'h4D, 8'h4D, 1);
    push(8'h55, 8'h55, 1);
    #1;
    tick();
    begin
      int stall = 0;
      for (int i = 0; i < 50; i++) begin
        if (tx_wr || rx_rd) stall++;
        tick();
      end
      chk("t5_stall", 32'(stall), 0);
    end
    chk("t5_mode", 32'(mode_o), 1);
    tx_full = 1'b0;
    #1;
    chk("t5_txwr", 32'(tx_wr), 1);
    chk("t5_txdata", 32'(tx_wdata), 'h4D);
    chk("t5_no_rd", 32'(rx_rd), 0);
    tick(); chk("t5_rd2", 32'(rx_rd), 1);
    ticks(6);
    drain("t5");

    // 6: reset while stalled in SEND drops the pending echo
    tx_full = 1'b1;
    push(8'h52, 8'h00, 0);
    #1;
    ticks(4);
    rst = 1'b1;
    tick();
    chk("t6_outs", 32'({rx_rd, tx_wr, run_o, mode_o, clear_o, up_o, down_o}), 0);
    chk("t6_err", 32'(err_cnt), 0);
    rst = 1'b0;
    tx_full = 1'b0;
    ticks(5);
    drain("t6");
    push(8'h44, 8'h44, 1);
    #1 chk("t6_idle_rd", 32'(rx_rd), 1);
    ticks(6);
    drain("t6b");

    chk("rd_wr_overlap", 32'(overlap), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
